// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write-port bundle for the program loader.
// The loader takes the slave side; the stream source / memory takes master.
interface imem_loader_if #(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 8
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: LEN / data words / CHK frame into IMEM.
// Keeps the CPU held in reset until a frame with a good checksum lands.
module imem_loader #(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] words_loaded
);
  localparam int BPW = INSTR_W / 8;

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CHK, DONE, ERR
  } state_t;

  state_t state, nstate;

  logic [7:0]         n_words;
  logic [7:0]         sum;
  logic [7:0]         byte_cnt;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W:0]    wcnt;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] nword;
  logic               accept;
  logic               last_byte;
  logic               last_word;
  logic               too_long;

  assign accept    = bus.in_valid && bus.in_ready;
  assign nword     = (word << 8) | INSTR_W'(bus.in_data);
  assign last_byte = byte_cnt == 8'(BPW - 1);
  assign last_word = 32'(wcnt) + 32'd1 == 32'(n_words);
  assign too_long  = 32'(bus.in_data) > (32'd1 << ADDR_W);

  assign bus.in_ready  = state inside {LEN, DATA, CHK};
  assign busy          = state inside {LEN, DATA, CHK};
  assign cpu_hold      = state inside {LEN, DATA, CHK, ERR};
  assign done          = state == DONE;
  assign err           = state == ERR;
  assign words_loaded  = wcnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state: load_start always restarts at LEN, even mid-frame
  always_comb begin
    nstate = state;
    if (load_start) begin
      nstate = LEN;
    end else begin
      case (state)
        LEN: if (accept) begin
          if (too_long)                nstate = ERR;
          else if (bus.in_data == '0)  nstate = CHK;
          else                         nstate = DATA;
        end
        DATA: if (accept && last_byte && last_word)
          nstate = CHK;
        CHK: if (accept)
          nstate = (bus.in_data == sum) ? DONE : ERR;
        default: ;
      endcase
    end
  end

  // Datapath: byte assembly, checksum, one-cycle-late IMEM write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words       <= '0;
      sum           <= '0;
      byte_cnt      <= '0;
      addr          <= '0;
      wcnt          <= '0;
      word          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (load_start) begin
        byte_cnt <= '0;
      end else if (accept) begin
        case (state)
          LEN: begin
            n_words  <= bus.in_data;
            sum      <= bus.in_data;
            addr     <= '0;
            wcnt     <= '0;
            byte_cnt <= '0;
          end
          DATA: begin
            sum  <= sum + bus.in_data;
            word <= nword;
            if (last_byte) begin
              byte_cnt      <= '0;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= addr;
              bus.mem_wdata <= nword;
              addr          <= addr + 1'b1;
              wcnt          <= wcnt + 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: 8-bit words with a write log,
// plus a 16-bit / 4-word instance for word assembly and length limits.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ls8 = 1'b0;
  logic ls16 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  imem_loader_if #(.INSTR_W(8), .ADDR_W(8)) i8 ();
  imem_loader_if #(.INSTR_W(16), .ADDR_W(2)) i16 ();

  logic       hold8, busy8, done8, err8;
  logic [8:0] wl8;
  logic       hold16, busy16, done16, err16;
  logic [2:0] wl16;

  imem_loader #(.INSTR_W(8), .ADDR_W(8)) u8 (
    .clk(clk), .rst(rst), .load_start(ls8),
    .bus(i8.slave), .cpu_hold(hold8),
    .busy(busy8), .done(done8), .err(err8),
    .words_loaded(wl8)
  );

  imem_loader #(.INSTR_W(16), .ADDR_W(2)) u16 (
    .clk(clk), .rst(rst), .load_start(ls16),
    .bus(i16.slave), .cpu_hold(hold16),
    .busy(busy16), .done(done16), .err(err16),
    .words_loaded(wl16)
  );

  always #5 clk = ~clk;

  logic [15:0] wq[$];

  always @(posedge clk)
    if (i8.mem_we === 1'b1)
      wq.push_back({i8.mem_addr, i8.mem_wdata});

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic start8();
    @(negedge clk); ls8 = 1'b1;
    @(posedge clk); #1 ls8 = 1'b0;
  endtask

  task automatic start16();
    @(negedge clk); ls16 = 1'b1;
    @(posedge clk); #1 ls16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    i8.in_data = b;
    i8.in_valid = 1'b1;
    @(posedge clk); #1 i8.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [7:0] b);
    @(negedge clk);
    i16.in_data = b;
    i16.in_valid = 1'b1;
    @(posedge clk); #1 i16.in_valid = 1'b0;
  endtask

  task automatic frame8(input logic [7:0] ck, input bit gaps);
    logic [7:0] f[5];
    f = '{8'h03, 8'h11, 8'h22, 8'h33, ck};
    for (int i = 0; i < 5; i++)
      send8(f[i], gaps ? int'($urandom_range(0, 5)) : 0);
  endtask

  task automatic chk_three(input string tag);
    chk({tag, "_n"}, 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk({tag, "_w0"}, 32'(wq[0]), 32'h0011);
      chk({tag, "_w1"}, 32'(wq[1]), 32'h0122);
      chk({tag, "_w2"}, 32'(wq[2]), 32'h0233);
    end
  endtask

  initial begin
    i8.in_data = '0;
    i8.in_valid = 1'b0;
    i16.in_data = '0;
    i16.in_valid = 1'b0;

    #12;
    chk("rst_hold", 32'(hold8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_flags", 32'({done8, err8}), 32'd0);
    chk("rst_ready", 32'(i8.in_ready), 32'd0);
    chk("rst_we", 32'(i8.mem_we), 32'd0);
    chk("rst_wl", 32'(wl8), 32'd0);
    @(negedge clk); rst = 1'b0;

    // good frame, back-to-back bytes
    start8();
    chk("ld_hold", 32'(hold8), 32'd1);
    chk("ld_busy", 32'(busy8), 32'd1);
    chk("ld_ready", 32'(i8.in_ready), 32'd1);
    frame8(8'h69, 1'b0);
    chk_three("ok");
    chk("ok_done", 32'({done8, err8}), 32'b10);
    chk("ok_hold", 32'(hold8), 32'd0);
    chk("ok_busy", 32'(busy8), 32'd0);
    chk("ok_wl", 32'(wl8), 32'd3);

    // bad checksum
    wq.delete();
    start8();
    chk("restart_done", 32'(done8), 32'd0);
    frame8(8'h6A, 1'b0);
    chk_three("bad");
    chk("bad_flags", 32'({done8, err8}), 32'b01);
    chk("bad_hold", 32'(hold8), 32'd1);

    // empty program
    wq.delete();
    start8();
    chk("reload_err", 32'(err8), 32'd0);
    send8(8'h00, 0);
    send8(8'h00, 0);
    chk("empty_n", 32'(wq.size()), 32'd0);
    chk("empty_wl", 32'(wl8), 32'd0);
    chk("empty_done", 32'(done8), 32'd1);

    // good frame with idle gaps between bytes
    wq.delete();
    start8();
    frame8(8'h69, 1'b1);
    chk_three("gap");
    chk("gap_done", 32'(done8), 32'd1);

    // reset while the first word's write is in flight
    wq.delete();
    start8();
    send8(8'h03, 0);
    send8(8'h11, 0);
    chk("pre_rst_we", 32'(i8.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(i8.mem_we), 32'd0);
    chk("mid_rst_hold", 32'(hold8), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_rdy", 32'(i8.in_ready), 32'd0);
    chk("mid_rst_wl", 32'(wl8), 32'd0);
    @(negedge clk); rst = 1'b0;
    start8();
    send8(8'h01, 0);
    send8(8'h55, 0);
    send8(8'h56, 0);
    chk("rld_n", 32'(wq.size()), 32'd1);
    if (wq.size() == 1)
      chk("rld_w0", 32'(wq[0]), 32'h0055);
    chk("rld_done", 32'(done8), 32'd1);

    // abort during DATA with a byte offered
    wq.delete();
    start8();
    send8(8'h02, 0);
    send8(8'hAA, 0);
    @(negedge clk);
    i8.in_data = 8'hBB;
    i8.in_valid = 1'b1;
    ls8 = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    ls8 = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd1);
    chk("abort_wl", 32'(wl8), 32'd1);
    send8(8'h01, 0);
    send8(8'h77, 0);
    send8(8'h78, 0);
    chk("abort_n", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("abort_w0", 32'(wq[0]), 32'h00AA);
      chk("abort_w1", 32'(wq[1]), 32'h0077);
    end
    chk("abort_done", 32'(done8), 32'd1);

    // 16-bit words, MSB first, write 1 cycle after 2nd byte
    start16();
    send16(8'h02);
    send16(8'hAB);
    chk("w16_idle_we", 32'(i16.mem_we), 32'd0);
    send16(8'hCD);
    chk("w16_we0", 32'(i16.mem_we), 32'd1);
    chk("w16_a0", 32'(i16.mem_addr), 32'd0);
    chk("w16_d0", 32'(i16.mem_wdata), 32'hABCD);
    send16(8'h12);
    chk("w16_we_gap", 32'(i16.mem_we), 32'd0);
    chk("w16_hold_d", 32'(i16.mem_wdata), 32'hABCD);
    send16(8'h34);
    chk("w16_we1", 32'(i16.mem_we), 32'd1);
    chk("w16_a1", 32'(i16.mem_addr), 32'd1);
    chk("w16_d1", 32'(i16.mem_wdata), 32'h1234);
    send16(8'hC0);
    chk("w16_done", 32'({done16, err16}), 32'b10);
    chk("w16_wl", 32'(wl16), 32'd2);

    // length limit: 4 words fits, 5 overflows
    start16();
    send16(8'h04);
    chk("len4_state", 32'({busy16, err16}), 32'b10);
    start16();
    send16(8'h05);
    chk("len5_err", 32'(err16), 32'd1);
    chk("len5_busy", 32'(busy16), 32'd0);
    chk("len5_hold", 32'(hold16), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
